// File: rtl/run_ctrl_pkg.sv
// Shared types and limits for the pipeline run controller.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RUN      = 2'd1,
        DONE     = 2'd2,
        TIMEOUT  = 2'd3
    } run_state_t;

    localparam int RUN_CTRL_MAX_CORES = 8;

endpackage

// File: rtl/retire_popcount.sv
// Combinational population count of the per-core retire strobes.
module retire_popcount #(
    parameter int NUM_CORES = 1,
    parameter int PC_W      = $clog2(NUM_CORES + 1)
) (
    input  logic [NUM_CORES-1:0] bits_in,
    output logic [PC_W-1:0]      count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            count = count + PC_W'(bits_in[i]);
        end
    end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run controller: holds cores in reset, counts RUN cycles and retired
// instructions, and flags completion or watchdog expiry.
// Optional PIPELINE_RUN_CTRL_TRACE_EN adds a simulation-only state trace.
module pipeline_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int NUM_CORES    = 1,
    parameter int RESET_CYCLES = 2,
    parameter int CNT_W        = 32,
    parameter int MAX_CYCLES   = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart,
    input  logic [NUM_CORES-1:0] halt,
    input  logic [NUM_CORES-1:0] retire,
    output logic                 core_reset,
    output logic                 running,
    output logic                 done,
    output logic                 timeout,
    output logic [NUM_CORES-1:0] halted_mask,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     instret
);

    localparam int PC_W   = $clog2(NUM_CORES + 1);
    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WD_LAST   = (MAX_CYCLES == 0) ? '0 : CNT_W'(MAX_CYCLES - 1);

    run_state_t           state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 core_reset_q, core_reset_d;
    logic                 running_q, running_d;
    logic                 done_q, done_d;
    logic                 timeout_q, timeout_d;
    logic [NUM_CORES-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]     cycle_q, cycle_d;
    logic [CNT_W-1:0]     instret_q, instret_d;

    logic [PC_W-1:0]      retire_cnt;
    logic [CNT_W:0]       cycle_sum;
    logic [CNT_W:0]       instret_sum;
    logic                 all_halted;
    logic                 wd_hit;

    retire_popcount #(
        .NUM_CORES (NUM_CORES),
        .PC_W      (PC_W)
    ) u_popcount (
        .bits_in (retire),
        .count   (retire_cnt)
    );

    // One extra carry bit lets the counters saturate instead of wrapping.
    assign cycle_sum   = {1'b0, cycle_q} + (CNT_W + 1)'(1);
    assign instret_sum = {1'b0, instret_q} + (CNT_W + 1)'(retire_cnt);
    assign all_halted  = &(mask_q | halt);
    assign wd_hit      = (MAX_CYCLES != 0) && (cycle_q == WD_LAST);

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        core_reset_d = core_reset_q;
        mask_d       = mask_q;
        cycle_d      = cycle_q;
        instret_d    = instret_q;
        if (restart) begin
            state_d      = RST_HOLD;
            hold_d       = '0;
            core_reset_d = 1'b1;
            mask_d       = '0;
            cycle_d      = '0;
            instret_d    = '0;
        end else begin
            case (state_q)
                RST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d      = RUN;
                        core_reset_d = 1'b0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                RUN: begin
                    cycle_d   = cycle_sum[CNT_W] ? '1 : cycle_sum[CNT_W-1:0];
                    instret_d = instret_sum[CNT_W] ? '1 : instret_sum[CNT_W-1:0];
                    mask_d    = mask_q | halt;
                    if (all_halted) begin
                        state_d = DONE;
                    end else if (wd_hit) begin
                        state_d = TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
        timeout_d = (state_d == TIMEOUT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RST_HOLD;
            hold_q       <= '0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            mask_q       <= '0;
            cycle_q      <= '0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            core_reset_q <= core_reset_d;
            running_q    <= running_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            mask_q       <= mask_d;
            cycle_q      <= cycle_d;
            instret_q    <= instret_d;
        end
    end

    assign core_reset  = core_reset_q;
    assign running     = running_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign halted_mask = mask_q;
    assign cycle_cnt   = cycle_q;
    assign instret     = instret_q;

`ifdef PIPELINE_RUN_CTRL_TRACE_EN
    always @(posedge clk) begin
        if (reset && (state_q != state_d)) begin
            $display("%0t run_ctrl: %s -> %s", $time, state_q.name(), state_d.name());
            if (state_d == DONE || state_d == TIMEOUT) begin
                $display("%0t run_ctrl: cycle_cnt=%0d instret=%0d halted_mask=%b",
                         $time, cycle_d, instret_d, mask_d);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Scoreboard bench: three controller instances (default, 4 cores, 4-bit
// counters without watchdog) run directed sequences in lockstep.
module tb_pipeline_run_ctrl;

    typedef struct {
        string      name;
        longint     cyc;
        longint     ins;
        logic       dn;
        logic       tmo;
        logic [3:0] mask;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic restart = 1'b0;

    logic       halt_a = 1'b0, retire_a = 1'b0;
    logic [3:0] halt_b = '0,   retire_b = '0;
    logic       halt_c = 1'b0, retire_c = 1'b0;

    logic        core_reset_a, running_a, done_a, timeout_a;
    logic [0:0]  mask_a;
    logic [31:0] cycle_a, instret_a;
    logic        core_reset_b, running_b, done_b, timeout_b;
    logic [3:0]  mask_b;
    logic [31:0] cycle_b, instret_b;
    logic        core_reset_c, running_c, done_c, timeout_c;
    logic [0:0]  mask_c;
    logic [3:0]  cycle_c, instret_c;

    int errors = 0;
    int checks = 0;
    exp_t qa[$], qb[$], qc[$];
    logic done_a_prev = 1'b0, tmo_a_prev = 1'b0;
    logic done_b_prev = 1'b0, tmo_b_prev = 1'b0;
    logic done_c_prev = 1'b0, tmo_c_prev = 1'b0;

    always #5 clk = ~clk;

    pipeline_run_ctrl u_a (
        .clk(clk), .reset(rst_n), .restart(restart),
        .halt(halt_a), .retire(retire_a),
        .core_reset(core_reset_a), .running(running_a), .done(done_a), .timeout(timeout_a),
        .halted_mask(mask_a), .cycle_cnt(cycle_a), .instret(instret_a)
    );

    pipeline_run_ctrl #(.NUM_CORES(4)) u_b (
        .clk(clk), .reset(rst_n), .restart(restart),
        .halt(halt_b), .retire(retire_b),
        .core_reset(core_reset_b), .running(running_b), .done(done_b), .timeout(timeout_b),
        .halted_mask(mask_b), .cycle_cnt(cycle_b), .instret(instret_b)
    );

    pipeline_run_ctrl #(.CNT_W(4), .MAX_CYCLES(0)) u_c (
        .clk(clk), .reset(rst_n), .restart(restart),
        .halt(halt_c), .retire(retire_c),
        .core_reset(core_reset_c), .running(running_c), .done(done_c), .timeout(timeout_c),
        .halted_mask(mask_c), .cycle_cnt(cycle_c), .instret(instret_c)
    );

    function automatic void check(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endfunction

    function automatic void compare(exp_t e, longint cyc, longint ins, logic dn,
                                    logic tmo, logic [3:0] mask);
        check({e.name, ".cycle_cnt"}, cyc, e.cyc);
        check({e.name, ".instret"}, ins, e.ins);
        check({e.name, ".done"}, longint'(dn), longint'(e.dn));
        check({e.name, ".timeout"}, longint'(tmo), longint'(e.tmo));
        check({e.name, ".halted_mask"}, longint'(mask), longint'(e.mask));
    endfunction

    // Monitors: a terminal-state entry is the DUT's "output event".
    always @(negedge clk) begin
        if (((done_a && !done_a_prev) || (timeout_a && !tmo_a_prev)) && qa.size() > 0)
            compare(qa.pop_front(), longint'(cycle_a), longint'(instret_a), done_a, timeout_a, {3'b0, mask_a});
        if (((done_b && !done_b_prev) || (timeout_b && !tmo_b_prev)) && qb.size() > 0)
            compare(qb.pop_front(), longint'(cycle_b), longint'(instret_b), done_b, timeout_b, mask_b);
        if (((done_c && !done_c_prev) || (timeout_c && !tmo_c_prev)) && qc.size() > 0)
            compare(qc.pop_front(), longint'(cycle_c), longint'(instret_c), done_c, timeout_c, {3'b0, mask_c});
        done_a_prev <= done_a;
        tmo_a_prev  <= timeout_a;
        done_b_prev <= done_b;
        tmo_b_prev  <= timeout_b;
        done_c_prev <= done_c;
        tmo_c_prev  <= timeout_c;
    end

    // Counts rising edges until core_reset is seen low; leaves us at a negedge.
    task automatic wait_run(string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (core_reset_a && n < 10);
        check({name, ".core_reset_edges"}, longint'(n), 2);
        check({name, ".running"}, longint'(running_a), 1);
    endtask

    task automatic check_cleared(string name);
        check({name, ".a.core_reset"}, longint'(core_reset_a), 1);
        check({name, ".a.cycle_cnt"}, longint'(cycle_a), 0);
        check({name, ".a.instret"}, longint'(instret_a), 0);
        check({name, ".a.flags"}, longint'({running_a, done_a, timeout_a, mask_a}), 0);
        check({name, ".b.core_reset"}, longint'(core_reset_b), 1);
        check({name, ".b.counters"}, longint'(cycle_b) + longint'(instret_b), 0);
        check({name, ".b.flags"}, longint'({running_b, done_b, timeout_b, mask_b}), 0);
        check({name, ".c.counters"}, longint'(cycle_c) + longint'(instret_c), 0);
    endtask

    task automatic pulse_restart(string name);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check_cleared(name);
    endtask

    initial begin
        // Reset state, then release at 20 ns.
        @(negedge clk);
        check_cleared("reset");
        #10 rst_n = 1'b1;
        wait_run("release");

        // Phase 1: A halts on cycle 10, B in two halves, C after saturation.
        qa.push_back('{"p1.a", 10, 10, 1'b1, 1'b0, 4'b0001});
        qb.push_back('{"p1.b", 9, 36, 1'b1, 1'b0, 4'b1111});
        qc.push_back('{"p1.c", 15, 15, 1'b1, 1'b0, 4'b0001});
        for (int i = 1; i <= 22; i++) begin
            if (i == 6) begin
                check("p1.b.mask_partial", longint'(mask_b), 5);
                check("p1.b.instret_partial", longint'(instret_b), 20);
            end
            halt_a = (i == 10); retire_a = 1'b1;
            halt_b = (i == 5) ? 4'b0101 : (i == 9) ? 4'b1010 : 4'b0000; retire_b = 4'b1111;
            halt_c = (i == 20); retire_c = 1'b1;
            @(negedge clk);
        end
        halt_a = 1'b0; halt_b = '0; halt_c = 1'b0;
        @(negedge clk);
        check("p1.a.frozen_cycle", longint'(cycle_a), 10);
        check("p1.a.running_off", longint'(running_a), 0);
        check("p1.queues_empty", longint'(qa.size() + qb.size() + qc.size()), 0);

        // Phase 2: restart from DONE; A times out, B finishes on the watchdog cycle.
        pulse_restart("restart_done");
        wait_run("restart_done");
        qa.push_back('{"p2.a", 20, 20, 1'b0, 1'b1, 4'b0000});
        qb.push_back('{"p2.b", 20, 40, 1'b1, 1'b0, 4'b1111});
        for (int i = 1; i <= 23; i++) begin
            halt_a = 1'b0; retire_a = 1'b1;
            halt_b = (i == 20) ? 4'b1111 : 4'b0000; retire_b = 4'b0011;
            @(negedge clk);
        end
        halt_b = '0;
        check("p2.a.frozen_instret", longint'(instret_a), 20);
        check("p2.a.timeout_held", longint'(timeout_a), 1);
        check("p2.queues_empty", longint'(qa.size() + qb.size()), 0);

        // Phase 3: restart, run 7 cycles, then asynchronous reset mid-RUN.
        pulse_restart("restart_timeout");
        wait_run("restart_timeout");
        for (int i = 1; i <= 7; i++) begin
            retire_a = 1'b1; retire_b = 4'b0001;
            @(negedge clk);
        end
        check("p3.a.cycle_before_reset", longint'(cycle_a), 7);
        #2 rst_n = 1'b0;
        #1 check_cleared("async_reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_run("reset_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
